// File: rtl/bch_encode_pkg.sv
// Shared BCH definitions: the code parameter vector, GF(2^m) helpers, the
// generator polynomial and the chunk-count helpers used by the encoder.
package bch_encode_pkg;

  localparam int BCH_PARAM_SZ = 26;
  localparam int BCH_MAX_M    = 10;
  localparam int BCH_MAX_ECC  = 256;

  // Code parameters: field degree m, correction capability t, message bits k.
  typedef struct packed {
    logic [4:0]  m;
    logic [4:0]  t;
    logic [15:0] k;
  } bch_params_t;

  // Default code: BCH(15,7), t=2.
  localparam bch_params_t BCH_SANE = '{m: 5'd4, t: 5'd2, k: 16'd7};

  localparam logic [BCH_MAX_M-1:0] GF_ONE   = BCH_MAX_M'(1);
  localparam logic [BCH_MAX_M-1:0] GF_ALPHA = BCH_MAX_M'(2);
  localparam logic [BCH_MAX_ECC:0] POLY_ONE = (BCH_MAX_ECC + 1)'(1);

  function automatic int bch_m(input bch_params_t p);
    return int'(p.m);
  endfunction

  function automatic int bch_t(input bch_params_t p);
    return int'(p.t);
  endfunction

  function automatic int bch_data_bits(input bch_params_t p);
    return int'(p.k);
  endfunction

  // Primitive polynomial defining GF(2^m), including the x^m term.
  function automatic logic [BCH_MAX_M:0] bch_prim_poly(input int m);
    case (m)
      3:       return 11'h00B;
      4:       return 11'h013;
      5:       return 11'h025;
      6:       return 11'h043;
      7:       return 11'h089;
      8:       return 11'h11D;
      9:       return 11'h211;
      default: return 11'h409;
    endcase
  endfunction

  // Shift-and-add multiply in GF(2^m).
  function automatic logic [BCH_MAX_M-1:0] gf_mul(input logic [BCH_MAX_M-1:0] a,
                                                  input logic [BCH_MAX_M-1:0] b,
                                                  input int m);
    logic [BCH_MAX_M:0]   aa;
    logic [BCH_MAX_M:0]   prim;
    logic [BCH_MAX_M-1:0] r;
    prim = bch_prim_poly(m);
    aa   = {1'b0, a};
    r    = '0;
    for (int i = 0; i < m; i++) begin
      if (b[i]) r ^= aa[BCH_MAX_M-1:0];
      aa = aa << 1;
      if (aa[m]) aa ^= prim;
    end
    return r;
  endfunction

  // Generator polynomial with its leading term: product of the minimal
  // polynomials of alpha^i over the distinct cyclotomic cosets, i odd < 2t.
  function automatic logic [BCH_MAX_ECC:0] bch_gen_full(input bch_params_t p);
    int m, n, j, deg;
    logic done;
    logic [(1<<BCH_MAX_M)-1:0]            covered;
    logic [(BCH_MAX_M+1)*BCH_MAX_M-1:0]   mp;
    logic [BCH_MAX_M-1:0]                 a, lo;
    logic [BCH_MAX_ECC:0]                 g, gn;
    m       = bch_m(p);
    n       = (1 << m) - 1;
    covered = '0;
    g       = POLY_ONE;
    for (int i = 1; i < 2 * bch_t(p); i += 2) begin
      if (!covered[i]) begin
        a = GF_ONE;
        for (int e = 0; e < i; e++) a = gf_mul(a, GF_ALPHA, m);
        mp = '0;
        mp[BCH_MAX_M-1:0] = GF_ONE;
        deg  = 0;
        j    = i;
        done = 1'b0;
        while (!done) begin
          covered[j] = 1'b1;
          // mp *= (x + alpha^j), highest coefficient first so mp[k-1] is still old
          for (int k = deg + 1; k >= 0; k--) begin
            lo = '0;
            if (k > 0) lo = mp[(k-1)*BCH_MAX_M +: BCH_MAX_M];
            mp[k*BCH_MAX_M +: BCH_MAX_M] = lo ^ gf_mul(a, mp[k*BCH_MAX_M +: BCH_MAX_M], m);
          end
          deg++;
          a    = gf_mul(a, a, m);
          j    = (2 * j) % n;
          done = (j == i);
        end
        // Minimal polynomial coefficients are all 0/1: multiply into g over GF(2).
        gn = '0;
        for (int k = 0; k <= deg; k++)
          if (mp[k*BCH_MAX_M]) gn ^= g << k;
        g = gn;
      end
    end
    return g;
  endfunction

  function automatic int bch_ecc_bits(input bch_params_t p);
    logic [BCH_MAX_ECC:0] g;
    int d;
    g = bch_gen_full(p);
    d = 0;
    for (int i = 0; i <= BCH_MAX_ECC; i++) if (g[i]) d = i;
    return d;
  endfunction

  // Generator polynomial without its implicit leading 1 (caller slices ECC bits).
  function automatic logic [BCH_MAX_ECC-1:0] bch_gen_poly(input bch_params_t p);
    logic [BCH_MAX_ECC:0] g;
    g = bch_gen_full(p);
    return g[BCH_MAX_ECC-1:0];
  endfunction

  function automatic int bch_dcyc(input bch_params_t p, input int bits);
    return (bch_data_bits(p) + bits - 1) / bits;
  endfunction

  function automatic int bch_ecyc(input bch_params_t p, input int bits);
    return (bch_ecc_bits(p) + bits - 1) / bits;
  endfunction

endpackage

// File: rtl/bch_encode_lfsr.sv
// Parity register of the systematic BCH encoder: BITS-wide division step while
// absorbing message bits, BITS-wide left shift while emitting parity.
module bch_encode_lfsr #(
  parameter int             ECC   = 8,
  parameter int             BITS  = 1,
  parameter logic [ECC-1:0] GPOLY = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            absorb_i,
  input  logic            shift_i,
  input  logic [BITS-1:0] din_i,
  output logic [BITS-1:0] top_o
);

  logic [ECC-1:0] par_q, par_d, p;
  logic           fb;

  // Next parity: optional clear, then either absorb BITS message bits (MSB
  // first) or shift BITS parity bits out of the top.
  always_comb begin
    p  = clear_i ? '0 : par_q;
    fb = 1'b0;
    if (absorb_i) begin
      for (int b = BITS - 1; b >= 0; b--) begin
        fb = din_i[b] ^ p[ECC-1];
        p  = (p << 1) ^ (fb ? GPOLY : '0);
      end
    end else if (shift_i) begin
      p = p << BITS;
    end
    par_d = p;
  end

  // Parity register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= '0;
    else       par_q <= par_d;
  end

  assign top_o = par_q[ECC-1 -: BITS];

endmodule

// File: rtl/bch_encode.sv
// Systematic BCH encoder: message chunks pass through with one cycle of
// latency, then the parity chunks follow back to back, MSB first.
module bch_encode
  import bch_encode_pkg::*;
#(
  parameter logic [BCH_PARAM_SZ-1:0] P    = BCH_SANE,
  parameter int                      BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            data_valid,
  input  logic [BITS-1:0] data_in,
  output logic            ready,
  output logic            out_valid,
  output logic            first,
  output logic            last,
  output logic [BITS-1:0] data_out
);

  localparam int ECC  = bch_ecc_bits(P);
  localparam int DCYC = bch_dcyc(P, BITS);
  localparam int ECYC = bch_ecyc(P, BITS);
  localparam int DPAD = DCYC * BITS - bch_data_bits(P);
  localparam int CMAX = (DCYC > ECYC) ? DCYC : ECYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [ECC-1:0]  GPOLY    = ECC'(bch_gen_poly(P));
  // Pad bits of the first chunk are forced to zero so they cannot disturb parity.
  localparam logic [BITS-1:0] PAD_MASK = {BITS{1'b1}} >> DPAD;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_ECC  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic            ov_q, ov_d, first_q, first_d, last_q, last_d;
  logic [BITS-1:0] dout_q, dout_d;
  logic            take_start, take_data;
  logic [BITS-1:0] din;
  logic            lf_clear, lf_absorb, lf_shift;
  logic [BITS-1:0] par_top;

  assign ready      = (state_q != S_ECC);
  assign take_start = ready & data_valid & start;
  assign take_data  = take_start | ((state_q == S_DATA) & data_valid);
  assign din        = take_start ? (data_in & PAD_MASK) : data_in;

  bch_encode_lfsr #(.ECC(ECC), .BITS(BITS), .GPOLY(GPOLY)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (lf_clear),
    .absorb_i (lf_absorb),
    .shift_i  (lf_shift),
    .din_i    (din),
    .top_o    (par_top)
  );

  // Control: accepted chunks are absorbed and echoed; in ECC the parity is
  // shifted out one chunk per cycle. A start accepted in DATA restarts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_nxt   = '0;
    ov_d      = 1'b0;
    first_d   = 1'b0;
    last_d    = 1'b0;
    dout_d    = '0;
    lf_clear  = 1'b0;
    lf_absorb = 1'b0;
    lf_shift  = 1'b0;
    if (take_data) begin
      lf_clear  = take_start;
      lf_absorb = 1'b1;
      ov_d      = 1'b1;
      first_d   = take_start;
      dout_d    = din;
      cnt_nxt   = take_start ? CW'(1) : cnt_q + 1'b1;
      if (cnt_nxt == CW'(DCYC)) begin
        state_d = S_ECC;
        cnt_d   = '0;
      end else begin
        state_d = S_DATA;
        cnt_d   = cnt_nxt;
      end
    end else if (state_q == S_ECC) begin
      lf_shift = 1'b1;
      ov_d     = 1'b1;
      dout_d   = par_top;
      if (cnt_q == CW'(ECYC - 1)) begin
        last_d  = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State, chunk counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      first_q <= first_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
    end
  end

  assign out_valid = ov_q;
  assign first     = first_q;
  assign last      = last_q;
  assign data_out  = dout_q;

endmodule

// File: doc/bch_encode.md
Name: bch_encode

Overview:
- Systematic BCH encoder. It is the transmit-side counterpart of the decoder chain (syndrome, sigma, Chien search).
- Accepts `BCH_DATA_BITS(P)` message bits, BITS per cycle, MSB first.
- Passes the message through with one cycle of latency, then appends `BCH_ECC_BITS(P)` parity bits, BITS per cycle.
- Output is the codeword the decoder consumes.

Parameters:
- P, `BCH_SANE`, BCH code parameter vector (`BCH_PARAM_SZ` bits); supplies M, T, data and ECC bit counts.
- BITS, 1, bits accepted and emitted per clock; 1 <= BITS <= `BCH_ECC_BITS(P)`.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- reset, input, 1, asynchronous, active-high; clears all state.
- start, input, 1, qualifies the first data chunk of a new message (requires data_valid).
- data_valid, input, 1, data_in holds a valid chunk this cycle.
- data_in, input, BITS, message chunk; MSB is the earliest bit.
- ready, output, 1, encoder accepts data this cycle.
- out_valid, output, 1, data_out holds a codeword chunk.
- first, output, 1, with out_valid on the first codeword chunk.
- last, output, 1, with out_valid on the final ECC chunk.
- data_out, output, BITS, codeword chunk; MSB is the earliest bit.

Behaviour:
- Constants:
  - DCYC = ceil(DATA_BITS/BITS); ECYC = ceil(ECC_BITS/BITS).
  - DPAD = DCYC*BITS - DATA_BITS; EPAD = ECYC*BITS - ECC_BITS.
  - G = generator polynomial (degree ECC_BITS, implicit leading 1).
- Reset values: ready=1, out_valid=0, first=0, last=0, data_out=0, parity register=0, state=IDLE, counter=0.
- Padding:
  - The first data chunk carries DPAD leading (MSB-side) zero pad bits.
  - Leading zeros do not alter the remainder, so the LFSR absorbs them unchanged.
  - The final ECC chunk carries EPAD zero bits in its LSBs.
- State IDLE, ready=1:
  - start & data_valid: clear the parity register, absorb the chunk, set counter=1.
  - Move to ECC if DCYC==1, else to DATA.
  - data_valid without start is ignored (no output).
- State DATA, ready=1:
  - data_valid: absorb the chunk and increment the counter.
  - When the counter reaches DCYC, go to ECC.
  - data_valid low: stall; parity and counter hold; out_valid=0 next cycle.
- Absorb step: the parity register is stepped BITS times in one cycle.
  - Per bit: fb = in_bit ^ par[MSB]; par = (par<<1) ^ (fb ? G : 0).
- Data output timing:
  - Each accepted chunk appears on data_out the next cycle with out_valid=1.
  - first=1 on the chunk accepted with start.
- State ECC, ready=0:
  - Emits the ECYC parity chunks on consecutive cycles, starting the cycle after the last data chunk is shown, with no gap.
  - Parity is shifted out MSB first; there is no output backpressure.
  - last=1 with the final chunk; the next cycle ready=1 and state=IDLE.
- Latency: codeword chunk k (0-based) appears exactly 1 cycle after input chunk k is accepted. Parity chunk j appears DCYC+1+j cycles after start when there are no stalls.
- Simultaneous events:
  - start in DATA aborts the current message: parity is cleared and the new chunk is chunk 0 (first=1).
  - start or data_valid in ECC is ignored because ready=0.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously); partial codewords are discarded.
- The encoder never outputs X after reset.

Decomposition:
- Shared package, the existing `bch_defs.vh` / `bch.vh`, extended with:
  - a generator-polynomial function of P, returning ECC_BITS bits;
  - DCYC/ECYC helper macros.
- Reuse the existing lfsr_counter for chunk counting, with terminal values from lfsr_count.
- One natural sub-module: bch_encode_lfsr.
  - It holds the ECC_BITS parity register.
  - It implements the BITS-wide absorb step and the BITS-wide shift-out step.
  - It takes clear/absorb/shift controls.

Test Plan:
- Reset, then idle 10 cycles -> ready=1, out_valid=0, data_out=0 throughout.
- BCH(15,7) t=2 (G=x^8+x^7+x^6+x^4+1), BITS=1, message 0000001 -> data_out stream 0000001 then 11010001; first on the 1st bit, last on the 15th; ready low during the 8 ECC cycles.
- Same code, BITS=3, message 0000001 -> chunks 000, 000, 001, then 110, 100, 010 on 6 consecutive cycles; last on 010.
- Stall: BITS=3, deassert data_valid for 2 cycles between chunks 1 and 2 -> out_valid gaps of 2 cycles, identical parity 110, 100, 010.
- Restart and linearity: assert start mid-DATA with a new message -> the new codeword is correct. Also, random messages a, b satisfy ECC(a^b) == ECC(a)^ECC(b), and all-zero data gives all-zero ECC.
- Reset asserted during ECC output -> outputs clear the same cycle, ready=1. A following message encodes correctly.
